// File: rtl/tqvp_bus_if.sv
// Bundle of signals between the bus initiator and its surroundings:
// the command byte stream in, the response byte stream out, and the
// TinyQV peripheral data bus.
//
// Handshake rule for both byte streams: a byte moves on a rising clock
// edge where valid and ready are both high. The sender holds the byte
// and valid steady until that edge. The receiver may raise or lower
// ready at any time.
//
// Modports:
//   master - the initiator: consumes commands, produces responses and
//            drives the peripheral bus.
//   slave  - the host/peripheral side (a testbench or a wrapper).
interface tqvp_bus_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [5:0]  p_address;
    logic [31:0] p_data_in;
    logic [1:0]  p_data_write_n;
    logic [1:0]  p_data_read_n;
    logic [31:0] p_data_out;
    logic        p_data_ready;

    modport master (
        input  cmd_valid, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output p_address, p_data_in, p_data_write_n, p_data_read_n,
        input  p_data_out, p_data_ready
    );

    modport slave (
        output cmd_valid, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  p_address, p_data_in, p_data_write_n, p_data_read_n,
        output p_data_out, p_data_ready
    );
endinterface

// File: rtl/tqvp_bus_initiator.sv
// Command-driven initiator for the TinyQV peripheral data bus.
// A command arrives as a byte stream: a header (bit7 = write, bits1:0 =
// size), an address byte, and for writes 1/2/4 data bytes sent LSB first.
// The block runs one bus read or write. It answers with a status byte
// (00 ok, 01 read timeout, 02 bad size). After a successful read, the
// status byte is followed by the read bytes, LSB first.
//
// Ports:
//   clk, rst_n - clock; asynchronous active-low reset
//   bus        - tqvp_bus_if.master (command/response streams, peripheral bus)
//   busy       - high whenever the FSM is not waiting for a header
//   dbg_state  - current FSM state, for observation only
module tqvp_bus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tqvp_bus_if.master       bus,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_HDR    = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_STATUS = 3'd5;
    localparam logic [2:0] S_RDATA  = 3'd6;

    // The last READ cycle with data_ready low happens when the counter is
    // one short of TIMEOUT. Leaving READ at that point keeps the strobe
    // up for exactly TIMEOUT cycles.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic          rw_q, rw_d;
    logic [1:0]    size_q, size_d;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    code_q, code_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_idx;

    // Index of the final byte for the latched size: 1, 2 or 4 bytes.
    always_comb begin
        case (size_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        code_d  = code_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_HDR: begin
                if (bus.cmd_valid) begin
                    rw_d    = bus.cmd_data[7];
                    size_d  = bus.cmd_data[1:0];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.cmd_valid) begin
                    addr_d = bus.cmd_data[5:0];
                    if (size_q == 2'b11) begin
                        code_d  = 8'h02;
                        state_d = S_STATUS;
                    end else if (rw_q) begin
                        wdata_d = '0;
                        idx_d   = 2'd0;
                        state_d = S_WDATA;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_WDATA: begin
                if (bus.cmd_valid) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = bus.cmd_data;
                    if (idx_q == last_idx) begin
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                code_d  = 8'h00;
                state_d = S_STATUS;
            end
            S_READ: begin
                if (bus.p_data_ready) begin
                    rdata_d = bus.p_data_out;
                    code_d  = 8'h00;
                    state_d = S_STATUS;
                end else if (cnt_q == TO_LAST) begin
                    code_d  = 8'h01;
                    state_d = S_STATUS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STATUS: begin
                if (bus.rsp_ready) begin
                    // Read bytes follow only a read that completed cleanly.
                    if (!rw_q && code_q == 8'h00) begin
                        idx_d   = 2'd0;
                        state_d = S_RDATA;
                    end else begin
                        state_d = S_HDR;
                    end
                end
            end
            S_RDATA: begin
                if (bus.rsp_ready) begin
                    if (idx_q == last_idx) begin
                        state_d = S_HDR;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is decoded from registered state, so an asynchronous
    // reset drops the strobes and rsp_valid at once.
    always_comb begin
        bus.cmd_ready      = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
        bus.rsp_valid      = (state_q == S_STATUS) || (state_q == S_RDATA);
        bus.rsp_data       = 8'h00;
        if (state_q == S_STATUS) begin
            bus.rsp_data = code_q;
        end else if (state_q == S_RDATA) begin
            bus.rsp_data = rdata_q[{idx_q, 3'b000} +: 8];
        end
        bus.p_address      = addr_q;
        bus.p_data_in      = wdata_q;
        bus.p_data_write_n = (state_q == S_WRITE) ? size_q : 2'b11;
        bus.p_data_read_n  = (state_q == S_READ)  ? size_q : 2'b11;
        busy               = (state_q != S_HDR);
        dbg_state          = state_q;
    end

endmodule
